typing_checker: RTL and testbench

- Consumer end of the word-sequence interface. Takes raw PS/2 scan-code bytes from the keyboard receiver and compares each make code with the expected character on comparison_data.
- A correct key pulses get_next_character, which shifts the next expected character in. When a word is complete, it pulses enable_next_level to load the next word.
- Also tracks progress, errors and levels for the score/VGA logic.

---
 rtl/typing_checker.sv | 189 ++++++++++++++++++
 tb/tb_typing_checker.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/typing_checker.sv
// typing_checker: compares PS/2 make codes against the expected character of
// the current word and drives the word-sequence interface.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   start               one-cycle pulse that starts the game from IDLE
//   key_data, key_valid raw scan-code byte and its one-cycle strobe
//   comparison_data     expected scan code of the current character
//   num_char            length of the current word (0 is treated as 1)
//   get_next_character  one-cycle pulse: advance to the next character
//   enable_next_level   one-cycle pulse: load the next word
//   char_count          correct characters typed in the current word
//   error_count         saturating count of mismatched make codes
//   level               words completed
//   busy                high while keys are accepted
//   game_over           sticky high once NUM_LEVELS words are completed
module typing_checker #(
    parameter int unsigned NUM_LEVELS    = 30,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned ERR_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       key_data,
    input  logic             key_valid,
    input  logic [7:0]       comparison_data,
    input  logic [7:0]       num_char,
    output logic             get_next_character,
    output logic             enable_next_level,
    output logic [7:0]       char_count,
    output logic [ERR_W-1:0] error_count,
    output logic [7:0]       level,
    output logic             busy,
    output logic             game_over
);

    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST =
        SETTLE_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [7:0] LAST_LEVEL = 8'(NUM_LEVELS);

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEVEL,
        S_SETTLE,
        S_ARMED,
        S_CHECK,
        S_ADVANCE,
        S_DONE
    } state_t;

    state_t                state;
    logic                  break_pending;
    logic                  ext_pending;
    logic [7:0]            last_make;
    logic [7:0]            code;
    logic [SETTLE_W-1:0]   settle_count;

    // Byte pre-filter decode: a make code is any non-prefix byte that is not
    // the tail of a break/extended sequence and not a typematic repeat.
    logic       filter_active;
    logic       is_break;
    logic       is_ext;
    logic       is_make;
    assign filter_active = key_valid && (state != S_IDLE) && (state != S_DONE);
    assign is_break      = (key_data == BREAK_CODE);
    assign is_ext        = (key_data == EXT_CODE);
    assign is_make       = filter_active && !is_break && !is_ext &&
                           !break_pending && !ext_pending && (key_data != last_make);

    // Word-completion and counter arithmetic.
    logic [7:0] word_len;
    logic [8:0] next_count;
    logic       more_chars;
    logic       match;
    logic [7:0] next_level;
    assign word_len   = (num_char == 8'd0) ? 8'd1 : num_char;
    assign next_count = {1'b0, char_count} + 9'd1;
    assign more_chars = next_count < {1'b0, word_len};
    assign match      = (code == comparison_data);
    assign next_level = level + 8'd1;

    // Game FSM with registered outputs and pre-filter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= S_IDLE;
            break_pending      <= 1'b0;
            ext_pending        <= 1'b0;
            last_make          <= 8'd0;
            code               <= 8'd0;
            settle_count       <= '0;
            get_next_character <= 1'b0;
            enable_next_level  <= 1'b0;
            char_count         <= 8'd0;
            error_count        <= '0;
            level              <= 8'd0;
            busy               <= 1'b0;
            game_over          <= 1'b0;
        end else begin
            get_next_character <= 1'b0;
            enable_next_level  <= 1'b0;

            if (filter_active) begin
                if (is_break) begin
                    break_pending <= 1'b1;
                    last_make     <= 8'd0;
                end else if (is_ext) begin
                    ext_pending <= 1'b1;
                end else if (break_pending || ext_pending) begin
                    break_pending <= 1'b0;
                    ext_pending   <= 1'b0;
                end else if (key_data != last_make) begin
                    last_make <= key_data;
                end
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state             <= S_LEVEL;
                        enable_next_level <= 1'b1;
                    end
                end
                S_LEVEL: begin
                    char_count   <= 8'd0;
                    settle_count <= '0;
                    state        <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_count == SETTLE_LAST) begin
                        state <= S_ARMED;
                        busy  <= 1'b1;
                    end else begin
                        settle_count <= settle_count + SETTLE_W'(1);
                    end
                end
                S_ARMED: begin
                    if (is_make) begin
                        code  <= key_data;
                        busy  <= 1'b0;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (match) begin
                        if (more_chars) begin
                            state              <= S_ADVANCE;
                            get_next_character <= 1'b1;
                        end else begin
                            // Last character: load the next word instead of
                            // advancing, so get and load never overlap.
                            char_count <= next_count[7:0];
                            level      <= next_level;
                            if (next_level == LAST_LEVEL) begin
                                state     <= S_DONE;
                                game_over <= 1'b1;
                            end else begin
                                state             <= S_LEVEL;
                                enable_next_level <= 1'b1;
                            end
                        end
                    end else begin
                        if (error_count != '1) begin
                            error_count <= error_count + ERR_W'(1);
                        end
                        state <= S_ARMED;
                        busy  <= 1'b1;
                    end
                end
                S_ADVANCE: begin
                    char_count <= next_count[7:0];
                    state      <= S_ARMED;
                    busy       <= 1'b1;
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_typing_checker.sv
// Directed testbench for typing_checker (NUM_LEVELS=3, SETTLE_CYCLES=4).
module tb_typing_checker;

    localparam int unsigned ERR_W = 16;

    logic             clk;
    logic             reset;
    logic             start;
    logic [7:0]       key_data;
    logic             key_valid;
    logic [7:0]       comparison_data;
    logic [7:0]       num_char;
    logic             get_next_character;
    logic             enable_next_level;
    logic [7:0]       char_count;
    logic [ERR_W-1:0] error_count;
    logic [7:0]       level;
    logic             busy;
    logic             game_over;

    int n_assert = 0;
    int n_fail   = 0;

    typing_checker #(
        .NUM_LEVELS(3),
        .SETTLE_CYCLES(4),
        .ERR_W(ERR_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .key_data(key_data),
        .key_valid(key_valid),
        .comparison_data(comparison_data),
        .num_char(num_char),
        .get_next_character(get_next_character),
        .enable_next_level(enable_next_level),
        .char_count(char_count),
        .error_count(error_count),
        .level(level),
        .busy(busy),
        .game_over(game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_key(input logic [7:0] b);
        key_data  = b;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_get"},   32'(get_next_character), 32'(0));
        chk({tag, "_en"},    32'(enable_next_level),  32'(0));
        chk({tag, "_cc"},    32'(char_count),         32'(0));
        chk({tag, "_err"},   32'(error_count),        32'(0));
        chk({tag, "_lvl"},   32'(level),              32'(0));
        chk({tag, "_busy"},  32'(busy),               32'(0));
        chk({tag, "_over"},  32'(game_over),          32'(0));
    endtask

    // Bounded wait for ARMED; an expired bound is reported as a failure.
    task automatic wait_busy(input string tag);
        for (int i = 0; i < 32 && !busy; i++) tick();
        chk(tag, 32'(busy), 32'(1));
    endtask

    initial begin
        reset           = 1'b1;
        start           = 1'b0;
        key_data        = 8'h00;
        key_valid       = 1'b0;
        comparison_data = 8'h24;
        num_char        = 8'd3;
        repeat (2) tick();
        chk_idle_outputs("reset");
        reset = 1'b0;

        // Start: one-cycle load pulse, busy SETTLE_CYCLES+1 cycles later.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_en", 32'(enable_next_level), 32'(1));
        chk("start_get", 32'(get_next_character), 32'(0));
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("settle_busy", 32'(busy), 32'(0));
            chk("settle_en", 32'(enable_next_level), 32'(0));
        end
        tick();
        chk("armed_busy", 32'(busy), 32'(1));

        // Correct key: get pulse two cycles after key_valid.
        send_key(8'h24);
        chk("k1_get_c1", 32'(get_next_character), 32'(0));
        tick();
        chk("k1_get_c2", 32'(get_next_character), 32'(1));
        tick();
        chk("k1_get_c3", 32'(get_next_character), 32'(0));
        chk("k1_cc", 32'(char_count), 32'(1));
        chk("k1_err", 32'(error_count), 32'(0));
        chk("k1_busy", 32'(busy), 32'(1));

        // Break sequence is not a make code (expected char held at 24).
        send_key(8'hF0);
        send_key(8'h24);
        tick();
        tick();
        chk("brk_cc", 32'(char_count), 32'(1));

        // 24 after the break counts; an immediate second 24 is a repeat.
        send_key(8'h24);
        tick();
        tick();
        chk("mk2_cc", 32'(char_count), 32'(2));
        send_key(8'h24);
        tick();
        tick();
        chk("rep_cc", 32'(char_count), 32'(2));
        chk("rep_lvl", 32'(level), 32'(0));

        // Release, then an extended key: never matches.
        send_key(8'hF0);
        send_key(8'h24);
        send_key(8'hE0);
        send_key(8'h24);
        tick();
        tick();
        chk("ext_cc", 32'(char_count), 32'(2));
        chk("ext_lvl", 32'(level), 32'(0));

        // Mismatch: 1C against expected 24.
        send_key(8'h1C);
        chk("mis_get_c1", 32'(get_next_character), 32'(0));
        tick();
        chk("mis_get_c2", 32'(get_next_character), 32'(0));
        chk("mis_err", 32'(error_count), 32'(1));
        chk("mis_busy", 32'(busy), 32'(1));
        chk("mis_cc", 32'(char_count), 32'(2));

        // F0,1C,24: third character of a 3-char word completes it.
        send_key(8'hF0);
        send_key(8'h1C);
        send_key(8'h24);
        tick();
        chk("w1_en", 32'(enable_next_level), 32'(1));
        chk("w1_get", 32'(get_next_character), 32'(0));
        chk("w1_lvl", 32'(level), 32'(1));
        tick();
        chk("w1_en_off", 32'(enable_next_level), 32'(0));
        chk("w1_cc0", 32'(char_count), 32'(0));

        // Full word 24/21/2B; release of the previous key arrives during settle.
        num_char        = 8'd3;
        comparison_data = 8'h24;
        send_key(8'hF0);
        send_key(8'h24);
        wait_busy("w2_armed");
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ignored", 32'(enable_next_level), 32'(0));

        send_key(8'h24);
        tick();
        chk("w2_get1", 32'(get_next_character), 32'(1));
        chk("w2_en1", 32'(enable_next_level), 32'(0));
        comparison_data = 8'h21;
        tick();
        chk("w2_cc1", 32'(char_count), 32'(1));
        send_key(8'hF0);
        send_key(8'h24);
        send_key(8'h21);
        tick();
        chk("w2_get2", 32'(get_next_character), 32'(1));
        chk("w2_en2", 32'(enable_next_level), 32'(0));
        comparison_data = 8'h2B;
        tick();
        chk("w2_cc2", 32'(char_count), 32'(2));
        send_key(8'hF0);
        send_key(8'h21);
        send_key(8'h2B);
        tick();
        chk("w2_en3", 32'(enable_next_level), 32'(1));
        chk("w2_get3", 32'(get_next_character), 32'(0));
        chk("w2_lvl", 32'(level), 32'(2));
        tick();
        chk("w2_cc0", 32'(char_count), 32'(0));

        // num_char=0 acts as 1; completing word 3 ends the game.
        num_char        = 8'd0;
        comparison_data = 8'h1C;
        send_key(8'hF0);
        send_key(8'h2B);
        wait_busy("w3_armed");
        send_key(8'h1C);
        tick();
        chk("w3_over", 32'(game_over), 32'(1));
        chk("w3_en", 32'(enable_next_level), 32'(0));
        chk("w3_get", 32'(get_next_character), 32'(0));
        chk("w3_lvl", 32'(level), 32'(3));
        chk("w3_busy", 32'(busy), 32'(0));

        // DONE holds: keys and start ignored.
        send_key(8'hF0);
        send_key(8'h1C);
        send_key(8'h33);
        send_key(8'h1C);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("done_lvl", 32'(level), 32'(3));
        chk("done_err", 32'(error_count), 32'(1));
        chk("done_over", 32'(game_over), 32'(1));
        chk("done_en", 32'(enable_next_level), 32'(0));
        chk("done_busy", 32'(busy), 32'(0));

        // New game after reset, then an asynchronous reset mid-word.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle_outputs("rst2");
        num_char        = 8'd3;
        comparison_data = 8'h24;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("g2_en", 32'(enable_next_level), 32'(1));
        wait_busy("g2_armed");
        send_key(8'h24);
        tick();
        comparison_data = 8'h21;
        tick();
        send_key(8'h21);
        tick();
        tick();
        chk("g2_cc", 32'(char_count), 32'(2));
        chk("g2_busy", 32'(busy), 32'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("arst_cc", 32'(char_count), 32'(0));
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_lvl", 32'(level), 32'(0));
        tick();
        reset = 1'b0;
        send_key(8'h24);
        tick();
        tick();
        chk("idle_busy", 32'(busy), 32'(0));
        chk("idle_get", 32'(get_next_character), 32'(0));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("idle_start_en", 32'(enable_next_level), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
